// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB4 completer backed by a word-addressed register memory. Runs the
// SETUP/ACCESS handshake with WAIT_CYCLES wait states per transfer, serves
// reads and byte-strobed writes, and flags misaligned or out-of-range
// addresses with PSLVERR.
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0).
// PENABLE then rises and the completer holds PREADY low for WAIT_CYCLES
// cycles. PREADY is high for exactly one cycle, the completion cycle. In that
// cycle PRDATA and PSLVERR are valid and a legal write commits at the
// following rising edge. Dropping PSEL during ACCESS aborts the transfer with
// no memory update.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   PSEL, PENABLE    select and access-phase strobes
//   PWRITE           1 = write, 0 = read
//   PADDR            byte address
//   PWDATA, PSTRB    write data and byte enables
//   PPROT            protection attributes (accepted, not used)
//   PRDATA           read data (zero unless a legal read completes)
//   PREADY           transfer completes this cycle
//   PSLVERR          error response, qualified by PREADY
//   dbg_state        current FSM state (0 = IDLE, 1 = ACCESS)
// -----------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  input  logic [2:0]            PPROT,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  dbg_state
);

  localparam int OFS   = $clog2(STRB_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  // One extra bit so the byte-size limit cannot overflow a narrow PADDR.
  localparam logic [ADDR_WIDTH:0] MEM_BYTES  = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LANE_MSK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic             legal;
  logic [IDX_W-1:0] idx;
  logic             wr_commit;

  // PPROT carries no meaning for this target.
  logic unused_pprot;
  assign unused_pprot = ^PPROT;

  // Alignment via a mask so the check also holds when OFS is zero (8-bit data).
  assign legal = ((PADDR & LANE_MSK) == '0) && ({1'b0, PADDR} < MEM_BYTES);
  assign idx   = PADDR[OFS +: IDX_W];

  assign PREADY    = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
  assign PSLVERR   = PREADY && !legal;
  assign PRDATA    = (PREADY && !PWRITE && legal) ? mem_q[idx] : '0;
  assign wr_commit = PREADY && PWRITE && legal;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_commit) begin
        for (int k = 0; k < STRB_WIDTH; k++) begin
          if (PSTRB[k]) begin
            mem_q[idx][8*k +: 8] <= PWDATA[8*k +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // PENABLE without a preceding setup cycle is ignored.
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Two completers share the clock and reset: index 0 has no wait states,
// index 1 has two. Each scenario task drives its own transfers and checks
// the responses against hand-computed values.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

  logic        clk;
  logic        rst_n;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [2:0]  pprot   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic        dbg_st  [2];

  int n_cmp;
  int n_err;

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  apb_slave_mem #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PPROT(pprot[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .dbg_state(dbg_st[0])
  );

  apb_slave_mem #(.WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PPROT(pprot[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .dbg_state(dbg_st[1])
  );

  // ---------------------------------------------------------------- drivers
  task automatic idle(input int d);
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // One full transfer. Returns right after sampling the completion cycle so a
  // following call places its setup in the very next cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input int exp_wait, input bit exp_err,
                      input logic [31:0] exp_rdata, input string name);
    bit done;
    @(posedge clk); #1;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    pstrb[d]   = strb;
    @(negedge clk);
    n_cmp++;
    if (pready[d] !== 1'b0) begin
      n_err++;
      $display("FAIL %s setup_pready: got %b want 0", name, pready[d]);
    end
    @(posedge clk); #1;
    penable[d] = 1'b1;
    done = 1'b0;
    for (int c = 0; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (pready[d] === 1'b1) begin
        done = 1'b1;
        n_cmp++;
        if (c != exp_wait) begin
          n_err++;
          $display("FAIL %s latency: got %0d wait cycles want %0d", name, c, exp_wait);
        end
        n_cmp++;
        if (pslverr[d] !== exp_err) begin
          n_err++;
          $display("FAIL %s pslverr: got %b want %b", name, pslverr[d], exp_err);
        end
        n_cmp++;
        if (prdata[d] !== exp_rdata) begin
          n_err++;
          $display("FAIL %s prdata: got %h want %h", name, prdata[d], exp_rdata);
        end
      end else begin
        n_cmp++;
        if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) begin
          n_err++;
          $display("FAIL %s wait_outputs: got prdata=%h pslverr=%b want 0/0",
                   name, prdata[d], pslverr[d]);
        end
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got no pready want pready within %0d cycles", name, exp_wait);
    end
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0 || dbg_st[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got ready=%b err=%b rdata=%h st=%b want 0/0/0/0",
                 d, pready[d], pslverr[d], prdata[d], dbg_st[d]);
      end
    end
  endtask

  task automatic test_zero_wait();
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,        "w0_write");
    xfer(0, 1'b0, 32'h08, 32'h0,        4'h0, 0, 1'b0, 32'hDEADBEEF, "w0_read");
    idle(0);
  endtask

  task automatic test_wait_states();
    xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, 2, 1'b0, 32'h0, "w2_read_reset_val");
    idle(1);
  endtask

  task automatic test_strobes();
    xfer(1, 1'b1, 32'h10, 32'h11223344, 4'hF, 2, 1'b0, 32'h0,        "strb_init");
    xfer(1, 1'b1, 32'h10, 32'hAABBCCDD, 4'h5, 2, 1'b0, 32'h0,        "strb_0101");
    xfer(1, 1'b0, 32'h10, 32'h0,        4'h0, 2, 1'b0, 32'h11BB33DD, "strb_read");
    xfer(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 2, 1'b0, 32'h0,        "strb_none");
    xfer(1, 1'b0, 32'h10, 32'h0,        4'h0, 2, 1'b0, 32'h11BB33DD, "strb_none_read");
    idle(1);
  endtask

  task automatic test_errors();
    xfer(1, 1'b1, 32'h04,  32'h01020304, 4'hF, 2, 1'b0, 32'h0,        "err_prefill");
    xfer(1, 1'b0, 32'h100, 32'h0,        4'h0, 2, 1'b1, 32'h0,        "err_read_oor");
    xfer(1, 1'b1, 32'h06,  32'hFFFFFFFF, 4'hF, 2, 1'b1, 32'h0,        "err_write_misalign");
    xfer(1, 1'b0, 32'h04,  32'h0,        4'h0, 2, 1'b0, 32'h01020304, "err_mem_unchanged");
    xfer(1, 1'b1, 32'hFC,  32'h89ABCDEF, 4'hF, 2, 1'b0, 32'h0,        "last_word_write");
    xfer(1, 1'b0, 32'hFC,  32'h0,        4'h0, 2, 1'b0, 32'h89ABCDEF, "last_word_read");
    idle(1);
  endtask

  task automatic test_abort();
    bit seen;
    xfer(1, 1'b1, 32'h04, 32'hCAFEF00D, 4'hF, 2, 1'b0, 32'h0, "abort_prefill");
    seen = 1'b0;
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h04; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
    @(negedge clk); seen |= pready[1];
    @(posedge clk); #1 penable[1] = 1'b1;
    @(negedge clk); seen |= pready[1];
    @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk); seen |= pready[1];
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pready: got %b want 0", seen);
    end
    @(negedge clk);
    n_cmp++;
    if (dbg_st[1] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: got %b want 0 (IDLE)", dbg_st[1]);
    end
    xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 2, 1'b0, 32'hCAFEF00D, "abort_read");
    idle(1);
  endtask

  task automatic test_reset_mid();
    xfer(1, 1'b1, 32'h0C, 32'h0BADF00D, 4'hF, 2, 1'b0, 32'h0, "rstmid_prefill");
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0C; pwdata[1] = 32'h77777777; pstrb[1] = 4'hF;
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pready[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_pready: got %b want 0", pready[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dbg_st[1] !== 1'b0 || pready[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_state: got st=%b ready=%b want 0/0", dbg_st[1], pready[1]);
    end
    xfer(1, 1'b0, 32'h0C, 32'h0,        4'h0, 2, 1'b0, 32'h0,        "rstmid_read");
    xfer(1, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, 2, 1'b0, 32'h0,        "b2b_write");
    xfer(1, 1'b0, 32'h20, 32'h0,        4'h0, 2, 1'b0, 32'h5A5A5A5A, "b2b_read");
    idle(1);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
    end
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_strobes();
    test_errors();
    test_abort();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB4 completer that sits directly downstream of the APB master on the `apb_int` bus. It decodes one select line (`PSEL0` or `PSEL1` at top level), runs the SETUP/ACCESS handshake with a programmable number of wait states, and serves reads and byte-strobed writes against an internal word-addressed register memory. Out-of-range or misaligned accesses complete with `PSLVERR`. It is the target the master's `PREADY`/`PRDATA` path is verified against.

## Interface
- `ADDR_WIDTH`, 32: width of `PADDR`.
- `DATA_WIDTH`, 32: width of `PWDATA`/`PRDATA`; must be 8, 16, 32 or 64.
- `STRB_WIDTH`, `DATA_WIDTH/8`: width of `PSTRB`.
- `MEM_DEPTH`, 64: number of data words; power of two, at least 2.
- `WAIT_CYCLES`, 2: wait states inserted per transfer, 0..15.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `PSEL` in 1: completer select.
- `PENABLE` in 1: access phase.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PADDR` in `ADDR_WIDTH`: byte address.
- `PWDATA` in `DATA_WIDTH`: write data.
- `PSTRB` in `STRB_WIDTH`: write byte enables.
- `PPROT` in 3: accepted, unused.
- `PRDATA` out `DATA_WIDTH`: read data.
- `PREADY` out 1: transfer completes this cycle.
- `PSLVERR` out 1: error response, qualified by `PREADY`.

## Operation
- `OFS = log2(STRB_WIDTH)`. Word index is `PADDR[OFS +: log2(MEM_DEPTH)]`.
- An address is legal when `PADDR[OFS-1:0] == 0` and `PADDR < MEM_DEPTH*STRB_WIDTH`. Any other address is an error.
- The FSM has two states, IDLE and ACCESS. Reset forces IDLE, counter = 0, and all memory words = 0.
- IDLE: on `PSEL && !PENABLE` (setup cycle), go to ACCESS and load the counter with `WAIT_CYCLES`. Anything else stays in IDLE; `PENABLE` without a preceding setup is ignored.
- ACCESS:
  - If `PSEL == 0`, abort: go to IDLE, no memory update.
  - Else if counter > 0, decrement and stay.
  - Else (counter == 0) this is the completion cycle: go to IDLE.
- Outputs (combinational decode):
  - `PREADY = (state == ACCESS) && PSEL && PENABLE && (counter == 0)`.
  - `PSLVERR = PREADY && address illegal`.
  - `PRDATA = mem[index]` when `PREADY && !PWRITE && legal`; otherwise all zeros.
- Write commit: at the rising edge ending a completion cycle with `PWRITE && legal`, byte lane k of `mem[index]` takes `PWDATA[8k+7:8k]` only where `PSTRB[k] == 1`. `PSTRB == 0` is a legal no-op write. Error writes never modify memory.
- `PADDR`, `PWRITE` and `PWDATA` are sampled in the completion cycle. The master is required to hold them stable from setup through completion.

## Timing
- Reset values: `PREADY` 0, `PSLVERR` 0, `PRDATA` 0.
- Transfer length is `2 + WAIT_CYCLES` cycles: setup at T0, `PREADY` high at `T1 + WAIT_CYCLES`.
- With `WAIT_CYCLES == 0`, `PREADY` is high in the first access cycle.
- `PREADY` is high for exactly one cycle per transfer.
- Back-to-back transfers: a setup in the cycle after completion is accepted. There is no idle gap beyond the protocol's own.
- Read-after-write to the same word in the next transfer returns the new data.
- A reset asserted mid-transfer returns the FSM to IDLE at that edge, drops `PREADY`, clears memory, and performs no write.
- Counter width is 4 bits and it never wraps: decrement happens only while > 0.

## Test plan
- `WAIT_CYCLES=0`: write `0xDEADBEEF` to `0x08` with `PSTRB=0xF`, then read `0x08`. `PREADY` is high in cycle T1 of each transfer; the read returns `0xDEADBEEF` with `PSLVERR=0`.
- `WAIT_CYCLES=2`: read `0x00` after reset. `PREADY` stays low at T1 and T2 and is high at T3; `PRDATA=0x00000000`.
- Byte strobes: with `0x11223344` at `0x10`, write `0xAABBCCDD` with `PSTRB=0b0101`, then read back `0x11BB33DD`.
- Errors: read `0x100` (MEM_DEPTH=64, 32-bit data) and write `0x06`. Both complete with `PREADY=1`, `PSLVERR=1`, `PRDATA=0`; memory is unchanged.
- Abort: setup a write of `0x12345678` to `0x04`, then drop `PSEL` during a wait state. No `PREADY` is seen, the FSM returns to IDLE, and a read of `0x04` returns the previous value.
- Reset mid-access: assert `rst_n=0` for one cycle during the wait of a write to `0x0C`. `PREADY` is 0 and a read of `0x0C` returns `0x00000000`. A back-to-back write→read pair then completes with no gap.
